pipe_hazard_ctrl: RTL and testbench



---
 rtl/pipe_hazard_ctrl_if.sv | 39 +++
 rtl/pipe_hazard_ctrl.sv | 172 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: decode/execute/memory status in, pipeline hold/flush controls out.
// master = pipeline side that reports status, slave = the hazard controller.
interface pipe_hazard_ctrl_if #(
  parameter int RF_SRC_W = 2
);
  logic [4:0]          id_rs;
  logic [4:0]          id_rt;
  logic                id_useRs;
  logic                id_useRt;
  logic                ex_rfWE;
  logic [4:0]          ex_rfDst;
  logic [RF_SRC_W-1:0] ex_rfSrc;
  logic                ex_branchPermit;
  logic                mem_busy;
  logic                pc_hold;
  logic                pc_redirect;
  logic                ifid_hold;
  logic                ifid_flush;
  logic                idex_hold;
  logic                idex_flush;
  logic                exmem_hold;
  logic                mem_timeout;
  logic [31:0]         stall_cnt;
  logic [31:0]         flush_cnt;

  modport master (
    output id_rs, id_rt, id_useRs, id_useRt, ex_rfWE, ex_rfDst, ex_rfSrc,
           ex_branchPermit, mem_busy,
    input  pc_hold, pc_redirect, ifid_hold, ifid_flush, idex_hold, idex_flush,
           exmem_hold, mem_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_useRs, id_useRt, ex_rfWE, ex_rfDst, ex_rfSrc,
           ex_branchPermit, mem_busy,
    output pc_hold, pc_redirect, ifid_hold, ifid_flush, idex_hold, idex_flush,
           exmem_hold, mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, branch squashes, memory waits.
// Optional hazard statistics counters are built when HAZARD_STATS_EN is defined.
module pipe_hazard_ctrl #(
  parameter int RF_SRC_W    = 2,
  parameter int LOAD_SRC    = 1,
  parameter int LOAD_LAT    = 1,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  pipe_hazard_ctrl_if.slave    hz
);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam int LD_W   = $clog2(LOAD_LAT + 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LSTALL = 2'd1,
    MWAIT  = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic                br_pend_r, br_pend_s;
  logic [WAIT_W-1:0]   wait_cnt_r, wait_cnt_s;
  logic [LD_W-1:0]     load_cnt_r, load_cnt_s;
  logic                timeout_r, timeout_s;
  logic                luse_s;
  logic                pc_hold_s, pc_redirect_s, ifid_hold_s, ifid_flush_s;
  logic                idex_hold_s, idex_flush_s, exmem_hold_s;

  assign luse_s = hz.ex_rfWE && (hz.ex_rfSrc == RF_SRC_W'(LOAD_SRC)) && (hz.ex_rfDst != 5'd0) &&
                  ((hz.id_useRs && (hz.id_rs == hz.ex_rfDst)) ||
                   (hz.id_useRt && (hz.id_rt == hz.ex_rfDst)));

  // Next-state and Mealy control decode; everything is quiet while reset is held.
  always_comb begin
    state_s       = state_r;
    br_pend_s     = br_pend_r;
    wait_cnt_s    = wait_cnt_r;
    load_cnt_s    = load_cnt_r;
    timeout_s     = timeout_r;
    pc_hold_s     = 1'b0;
    pc_redirect_s = 1'b0;
    ifid_hold_s   = 1'b0;
    ifid_flush_s  = 1'b0;
    idex_hold_s   = 1'b0;
    idex_flush_s  = 1'b0;
    exmem_hold_s  = 1'b0;
    if (!rst) begin
      state_s = RUN;
    end else begin
      case (state_r)
        RUN, LSTALL: begin
          if (hz.mem_busy) begin
            // A memory wait freezes everything, even an in-progress load-use stall.
            pc_hold_s    = 1'b1;
            ifid_hold_s  = 1'b1;
            idex_hold_s  = 1'b1;
            exmem_hold_s = 1'b1;
            br_pend_s    = hz.ex_branchPermit;
            state_s      = MWAIT;
            wait_cnt_s   = WAIT_W'(1);
            if (MEM_TIMEOUT <= 1) begin
              timeout_s = 1'b1;
            end else begin
              timeout_s = timeout_r;
            end
          end else if (state_r == LSTALL) begin
            pc_hold_s    = 1'b1;
            ifid_hold_s  = 1'b1;
            idex_flush_s = 1'b1;
            if (load_cnt_r <= LD_W'(1)) begin
              state_s = RUN;
            end else begin
              load_cnt_s = load_cnt_r - LD_W'(1);
            end
          end else if (hz.ex_branchPermit || br_pend_r) begin
            // The squash removes the dependent instruction, so no stall alongside it.
            pc_redirect_s = 1'b1;
            ifid_flush_s  = 1'b1;
            idex_flush_s  = 1'b1;
            br_pend_s     = 1'b0;
          end else if (luse_s) begin
            pc_hold_s    = 1'b1;
            ifid_hold_s  = 1'b1;
            idex_flush_s = 1'b1;
            if (LOAD_LAT > 1) begin
              state_s    = LSTALL;
              load_cnt_s = LD_W'(LOAD_LAT - 1);
            end else begin
              state_s = RUN;
            end
          end else begin
            state_s = RUN;
          end
        end
        MWAIT: begin
          br_pend_s = br_pend_r | hz.ex_branchPermit;
          if (hz.mem_busy) begin
            pc_hold_s    = 1'b1;
            ifid_hold_s  = 1'b1;
            idex_hold_s  = 1'b1;
            exmem_hold_s = 1'b1;
            if (wait_cnt_r < WAIT_W'(MEM_TIMEOUT)) begin
              wait_cnt_s = wait_cnt_r + WAIT_W'(1);
            end else begin
              wait_cnt_s = wait_cnt_r;
            end
            if (wait_cnt_s == WAIT_W'(MEM_TIMEOUT)) begin
              timeout_s = 1'b1;
            end else begin
              timeout_s = timeout_r;
            end
          end else begin
            state_s = RUN;
          end
        end
        default: begin
          state_s = RUN;
        end
      endcase
    end
  end

  // State, pending-branch, counters and sticky timeout registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= RUN;
      br_pend_r  <= 1'b0;
      wait_cnt_r <= '0;
      load_cnt_r <= '0;
      timeout_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      br_pend_r  <= br_pend_s;
      wait_cnt_r <= wait_cnt_s;
      load_cnt_r <= load_cnt_s;
      timeout_r  <= timeout_s;
    end
  end

  assign hz.pc_hold     = pc_hold_s;
  assign hz.pc_redirect = pc_redirect_s;
  assign hz.ifid_hold   = ifid_hold_s;
  assign hz.ifid_flush  = ifid_flush_s;
  assign hz.idex_hold   = idex_hold_s;
  assign hz.idex_flush  = idex_flush_s;
  assign hz.exmem_hold  = exmem_hold_s;
  assign hz.mem_timeout = timeout_r;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] flush_cnt_r;

  // Free-running wrap-around counts of PC stall cycles and branch flushes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_r <= 32'd0;
      flush_cnt_r <= 32'd0;
    end else begin
      stall_cnt_r <= stall_cnt_r + {31'd0, pc_hold_s};
      flush_cnt_r <= flush_cnt_r + {31'd0, ifid_flush_s};
    end
  end

  assign hz.stall_cnt = stall_cnt_r;
  assign hz.flush_cnt = flush_cnt_r;
`else
  assign hz.stall_cnt = 32'd0;
  assign hz.flush_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (load latency 1 and 3) share directed and random stimulus.
module tb_pipe_hazard_ctrl;
  localparam int TMO = 8;
  localparam logic [6:0] HOLDS = 7'b1010101;
  localparam logic [6:0] FLUSH = 7'b0101010;
  localparam logic [6:0] STALL = 7'b1010010;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.RF_SRC_W(2)) if_a ();
  pipe_hazard_ctrl_if #(.RF_SRC_W(2)) if_b ();

  pipe_hazard_ctrl #(.RF_SRC_W(2), .LOAD_SRC(1), .LOAD_LAT(1), .MEM_TIMEOUT(TMO)) dut_a (
    .clk(clk), .rst(rst), .hz(if_a.slave));
  pipe_hazard_ctrl #(.RF_SRC_W(2), .LOAD_SRC(1), .LOAD_LAT(3), .MEM_TIMEOUT(TMO)) dut_b (
    .clk(clk), .rst(rst), .hz(if_b.slave));

  logic [6:0]  obs [2];
  logic        tmo_obs [2];
  logic [31:0] scnt_obs [2];
  logic [31:0] fcnt_obs [2];
  assign obs[0] = {if_a.pc_hold, if_a.pc_redirect, if_a.ifid_hold, if_a.ifid_flush,
                   if_a.idex_hold, if_a.idex_flush, if_a.exmem_hold};
  assign obs[1] = {if_b.pc_hold, if_b.pc_redirect, if_b.ifid_hold, if_b.ifid_flush,
                   if_b.idex_hold, if_b.idex_flush, if_b.exmem_hold};
  assign tmo_obs[0]  = if_a.mem_timeout;
  assign tmo_obs[1]  = if_b.mem_timeout;
  assign scnt_obs[0] = if_a.stall_cnt;
  assign scnt_obs[1] = if_b.stall_cnt;
  assign fcnt_obs[0] = if_a.flush_cnt;
  assign fcnt_obs[1] = if_b.flush_cnt;

  logic [4:0] s_rs, s_rt, s_dst;
  logic       s_urs, s_urt, s_we, s_bp, s_busy;
  logic [1:0] s_src;

  // Reference model: plain counters of remaining stall cycles and busy length.
  bit          m_wait [2];
  int          m_left [2];
  int          m_blen [2];
  bit          m_pend [2];
  bit          m_tmo  [2];
  logic [31:0] m_scnt [2];
  logic [31:0] m_fcnt [2];

  int checks   = 0;
  int failures = 0;
  int busy_left = 0;

  task automatic idle();
    s_rs = 5'd0; s_rt = 5'd0; s_dst = 5'd0; s_urs = 1'b0; s_urt = 1'b0;
    s_we = 1'b0; s_bp = 1'b0; s_busy = 1'b0; s_src = 2'd0;
  endtask

  task automatic apply();
    if_a.id_rs = s_rs; if_a.id_rt = s_rt; if_a.id_useRs = s_urs; if_a.id_useRt = s_urt;
    if_a.ex_rfWE = s_we; if_a.ex_rfDst = s_dst; if_a.ex_rfSrc = s_src;
    if_a.ex_branchPermit = s_bp; if_a.mem_busy = s_busy;
    if_b.id_rs = s_rs; if_b.id_rt = s_rt; if_b.id_useRs = s_urs; if_b.id_useRt = s_urt;
    if_b.ex_rfWE = s_we; if_b.ex_rfDst = s_dst; if_b.ex_rfSrc = s_src;
    if_b.ex_branchPermit = s_bp; if_b.mem_busy = s_busy;
  endtask

  task automatic model(input int k, input bit luse, output logic [6:0] e);
    int lat;
    lat = (k == 0) ? 1 : 3;
    e = 7'b0;
    if (!rst) begin
      m_wait[k] = 1'b0; m_left[k] = 0; m_blen[k] = 0; m_pend[k] = 1'b0; m_tmo[k] = 1'b0;
    end else if (m_wait[k]) begin
      m_pend[k] = m_pend[k] | s_bp;
      if (s_busy) begin
        e = HOLDS;
        if (m_blen[k] < TMO) m_blen[k] = m_blen[k] + 1;
        if (m_blen[k] == TMO) m_tmo[k] = 1'b1;
      end else begin
        m_wait[k] = 1'b0;
      end
    end else if (s_busy) begin
      e = HOLDS; m_pend[k] = s_bp; m_wait[k] = 1'b1; m_blen[k] = 1; m_left[k] = 0;
    end else if (m_left[k] > 0) begin
      e = STALL; m_left[k] = m_left[k] - 1;
    end else if (s_bp || m_pend[k]) begin
      e = FLUSH; m_pend[k] = 1'b0;
    end else if (luse) begin
      e = STALL; m_left[k] = lat - 1;
    end
  endtask

  task automatic step();
    logic [6:0]  e;
    logic [31:0] es, ef;
    bit luse;
    apply();
    @(negedge clk);
    luse = s_we && (s_src == 2'd1) && (s_dst != 5'd0) &&
           ((s_urs && s_rs == s_dst) || (s_urt && s_rt == s_dst));
    for (int k = 0; k < 2; k++) begin
`ifdef HAZARD_STATS_EN
      es = m_scnt[k]; ef = m_fcnt[k];
`else
      es = 32'd0; ef = 32'd0;
`endif
      checks++;
      assert (tmo_obs[k] === m_tmo[k]) else begin
        failures++;
        $error("FAIL mem_timeout inst=%0d observed=%b expected=%b", k, tmo_obs[k], m_tmo[k]);
      end
      checks++;
      assert (scnt_obs[k] === es) else begin
        failures++;
        $error("FAIL stall_cnt inst=%0d observed=%0d expected=%0d", k, scnt_obs[k], es);
      end
      checks++;
      assert (fcnt_obs[k] === ef) else begin
        failures++;
        $error("FAIL flush_cnt inst=%0d observed=%0d expected=%0d", k, fcnt_obs[k], ef);
      end
      model(k, luse, e);
      checks++;
      assert (obs[k] === e) else begin
        failures++;
        $error("FAIL ctrl inst=%0d t=%0t observed=%b expected=%b", k, $time, obs[k], e);
      end
      if (!rst) begin
        m_scnt[k] = 32'd0; m_fcnt[k] = 32'd0;
      end else begin
        m_scnt[k] = m_scnt[k] + {31'd0, e[6]};
        m_fcnt[k] = m_fcnt[k] + {31'd0, e[3]};
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_wait[k] = 1'b0; m_left[k] = 0; m_blen[k] = 0; m_pend[k] = 1'b0; m_tmo[k] = 1'b0;
      m_scnt[k] = 32'd0; m_fcnt[k] = 32'd0;
    end
    rst = 1'b0;
    idle();
    apply();
    step(); step();
    rst = 1'b1;
    step();

    // load-use on r5
    s_we = 1'b1; s_src = 2'd1; s_dst = 5'd5; s_rs = 5'd5; s_urs = 1'b1;
    step();
    idle(); step(); step(); step();

    // taken branch alongside a load-use on r7
    s_we = 1'b1; s_src = 2'd1; s_dst = 5'd7; s_rt = 5'd7; s_urt = 1'b1; s_bp = 1'b1;
    step();
    idle(); step(); step();

    // branch arriving during a 4-cycle memory wait
    for (int i = 0; i < 4; i++) begin
      idle(); s_busy = 1'b1; s_bp = (i == 1); step();
    end
    idle(); step(); step(); step();

    // register zero and non-load writebacks never stall
    s_we = 1'b1; s_src = 2'd1; s_dst = 5'd0; s_rs = 5'd0; s_urs = 1'b1;
    step();
    s_src = 2'd2; s_dst = 5'd3; s_rs = 5'd3;
    step();
    idle(); step();

    // memory timeout, sticky until reset
    for (int i = 0; i < 10; i++) begin
      idle(); s_busy = 1'b1; step();
    end
    idle(); step(); step();
    rst = 1'b0; step();
    rst = 1'b1; step();

    // reset in the middle of a memory wait
    s_busy = 1'b1; s_bp = 1'b1; step(); step();
    rst = 1'b0; step();
    rst = 1'b1; idle(); step(); step();

    // reset in the middle of a multi-cycle load-use stall
    s_we = 1'b1; s_src = 2'd1; s_dst = 5'd2; s_rt = 5'd2; s_urt = 1'b1;
    step();
    rst = 1'b0; step();
    rst = 1'b1; idle(); step(); step();

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      rst   = ($urandom_range(0, 99) != 0);
      s_rs  = 5'($urandom_range(0, 3));
      s_rt  = 5'($urandom_range(0, 3));
      s_dst = 5'($urandom_range(0, 3));
      s_urs = 1'($urandom_range(0, 1));
      s_urt = 1'($urandom_range(0, 1));
      s_we  = 1'($urandom_range(0, 1));
      s_src = 2'($urandom_range(0, 3));
      s_bp  = ($urandom_range(0, 5) == 0);
      if (busy_left > 0) begin
        s_busy = 1'b1; busy_left--;
      end else if ($urandom_range(0, 11) == 0) begin
        s_busy = 1'b1; busy_left = $urandom_range(0, 11);
      end else begin
        s_busy = 1'b0;
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
